miriscv_int_ctrl: RTL and testbench

Interrupt controller between the 32 external request lines of `miriscv_top` (`int_req_i[31:0]`) and the core's trap logic. It selects one pending, enabled request and presents it to the core as a single interrupt with a cause code. It then tracks the core's take/return handshake and acknowledges the served source with a one-cycle pulse. Only one interrupt is in flight at a time; there is no nesting.

---
 rtl/miriscv_int_ctrl.sv | 133 +++++++++++++
 tb/tb_miriscv_int_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_int_ctrl.sv
// Interrupt controller: picks one pending, enabled request line, presents it to the core and pulses int_fin_o on mret.
// Build option MIRISCV_INT_FIXED_PRIO_EN selects a lowest-index-wins priority encoder instead of the round-robin scan.
module miriscv_int_ctrl #(
  parameter int N_SRC = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] int_req_i,
  input  logic [N_SRC-1:0] mie_i,
  input  logic             int_ack_i,
  input  logic             int_ret_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_SRC-1:0] int_fin_o
);

  localparam int IDW = $clog2(N_SRC);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t           state;
  logic [IDW-1:0]   id;
  logic             hit;
  logic [IDW-1:0]   sel;
  logic             cur_pend;
`ifndef MIRISCV_INT_FIXED_PRIO_EN
  logic [IDW-1:0]   cnt;
`endif

`ifdef MIRISCV_INT_FIXED_PRIO_EN
  // Lowest set bit wins; scanning downwards leaves the smallest index last.
  function automatic logic [IDW-1:0] first_set(input logic [N_SRC-1:0] v);
    logic [IDW-1:0] idx;
    idx = {IDW{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[IDW-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction
`endif

  // Candidate selection for SCAN and liveness of the presented request.
  always_comb begin
    hit      = 1'b0;
    sel      = {IDW{1'b0}};
`ifdef MIRISCV_INT_FIXED_PRIO_EN
    hit      = |(int_req_i & mie_i);
    sel      = first_set(int_req_i & mie_i);
`else
    hit      = int_req_i[cnt] & mie_i[cnt];
    sel      = cnt;
`endif
    cur_pend = int_req_i[id] & mie_i[id];
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= SCAN;
      id        <= {IDW{1'b0}};
`ifndef MIRISCV_INT_FIXED_PRIO_EN
      cnt       <= {IDW{1'b0}};
`endif
      int_o     <= 1'b0;
      int_fin_o <= {N_SRC{1'b0}};
      mcause_o  <= 32'd0;
    end else begin
      case (state)
        SCAN: begin
          int_fin_o <= {N_SRC{1'b0}};
          if (hit) begin
            id       <= sel;
            mcause_o <= {1'b1, {(31 - IDW){1'b0}}, sel};
            int_o    <= 1'b1;
            state    <= REQ;
          end else begin
            int_o    <= 1'b0;
`ifndef MIRISCV_INT_FIXED_PRIO_EN
            cnt      <= cnt + {{(IDW - 1){1'b0}}, 1'b1};
`endif
          end
        end
        REQ: begin
          // Ack wins over a same-cycle withdrawal.
          if (int_ack_i) begin
            int_o <= 1'b0;
            state <= SERVE;
          end else if (!cur_pend) begin
            int_o <= 1'b0;
`ifndef MIRISCV_INT_FIXED_PRIO_EN
            cnt   <= id + {{(IDW - 1){1'b0}}, 1'b1};
`endif
            state <= SCAN;
          end else begin
            int_o <= 1'b1;
          end
        end
        SERVE: begin
          int_o <= 1'b0;
          if (int_ret_i) begin
            int_fin_o <= {{(N_SRC - 1){1'b0}}, 1'b1} << id;
            state     <= FIN;
          end else begin
            int_fin_o <= {N_SRC{1'b0}};
          end
        end
        FIN: begin
          int_o     <= 1'b0;
          int_fin_o <= {N_SRC{1'b0}};
`ifndef MIRISCV_INT_FIXED_PRIO_EN
          cnt       <= id + {{(IDW - 1){1'b0}}, 1'b1};
`endif
          state     <= SCAN;
        end
        default: begin
          int_o     <= 1'b0;
          int_fin_o <= {N_SRC{1'b0}};
          state     <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_int_ctrl.sv
// Scenario-based bench for miriscv_int_ctrl; expected causes are queued when stimulus is driven and popped on int_o.
module tb_miriscv_int_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] int_req = 32'd0;
  logic [31:0] mie = 32'd0;
  logic        int_ack = 1'b0;
  logic        int_ret = 1'b0;
  logic        int_o;
  logic [31:0] mcause;
  logic [31:0] int_fin;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  miriscv_int_ctrl #(.N_SRC(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .int_req_i (int_req),
    .mie_i     (mie),
    .int_ack_i (int_ack),
    .int_ret_i (int_ret),
    .int_o     (int_o),
    .mcause_o  (mcause),
    .int_fin_o (int_fin)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; int_req = 32'd0; mie = 32'd0; int_ack = 1'b0; int_ret = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_int(input int max, output int cyc);
    cyc = 0;
    while (int_o !== 1'b1 && cyc < max) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; int_req = 32'hFFFF_FFFF; mie = 32'hFFFF_FFFF; int_ack = 1'b0; int_ret = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({int_o, int_fin, mcause} !== 65'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d: int_o=%b fin=%h mcause=%h, want 0/0/0", i, int_o, int_fin, mcause);
      end
    end
    rst = 1'b0;
    exp_q.push_back(32'h8000_0000);
    step();
    checks++;
    if (int_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_int: int_o=%b, want 1", int_o);
    end
    checks++;
    if (mcause !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL reset_first_cause: mcause=%h, want 80000000", mcause);
    end
  endtask

  task automatic test_single();
    int cyc;
    int bad;
    do_reset();
    int_req = 32'h2; mie = 32'h2;
    exp_q.push_back(32'h8000_0001);
    wait_int(40, cyc);
    checks++;
    if (int_o !== 1'b1) begin
      errors++;
      $display("FAIL single_int: int_o=%b after %0d cycles, want 1", int_o, cyc);
    end
    checks++;
    if (mcause !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL single_cause: mcause=%h, want 80000001", mcause);
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    checks++;
    if (int_o !== 1'b0 || int_fin !== 32'd0 || mcause !== 32'h8000_0001) begin
      errors++;
      $display("FAIL single_serve: int_o=%b fin=%h mcause=%h, want 0/0/80000001", int_o, int_fin, mcause);
    end
    int_ret = 1'b1; step(); int_ret = 1'b0; int_req = 32'd0;
    checks++;
    if (int_fin !== 32'h2) begin
      errors++;
      $display("FAIL single_fin: fin=%h, want 00000002", int_fin);
    end
    step();
    checks++;
    if (int_fin !== 32'd0) begin
      errors++;
      $display("FAIL single_fin_width: fin=%h, want 0", int_fin);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (int_o !== 1'b0 || int_fin !== 32'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_quiet: %0d active cycles after drop, want 0", bad);
    end
    checks++;
    if (mcause !== 32'h8000_0001) begin
      errors++;
      $display("FAIL single_cause_hold: mcause=%h, want 80000001", mcause);
    end
  endtask

  task automatic test_mask();
    int cyc;
    int bad;
    do_reset();
    int_req = 32'h10; mie = 32'd0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (int_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mask_block: int_o high %0d cycles, want 0", bad);
    end
    mie = 32'h10;
    exp_q.push_back(32'h8000_0004);
    wait_int(40, cyc);
    checks++;
    if (int_o !== 1'b1 || mcause !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL mask_enable: int_o=%b mcause=%h, want 1/80000004", int_o, mcause);
    end
    int_req = 32'd0;
    step();
    checks++;
    if (int_o !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_drop: int_o=%b, want 0", int_o);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (int_fin !== 32'd0 || int_o !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL withdraw_nofin: %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_fairness();
    int cyc;
    logic [31:0] exp;
    do_reset();
`ifdef MIRISCV_INT_FIXED_PRIO_EN
    exp_q.push_back(32'h8000_0000); exp_q.push_back(32'h8000_0000); exp_q.push_back(32'h8000_0000);
`else
    exp_q.push_back(32'h8000_0000); exp_q.push_back(32'h8000_0001); exp_q.push_back(32'h8000_001F);
    exp_q.push_back(32'h8000_0000); exp_q.push_back(32'h8000_0001); exp_q.push_back(32'h8000_001F);
`endif
    int_req = 32'h8000_0003; mie = 32'hFFFF_FFFF;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      wait_int(40, cyc);
      checks++;
      if (int_o !== 1'b1 || mcause !== exp) begin
        errors++;
        $display("FAIL fair_order: int_o=%b mcause=%h, want 1/%h", int_o, mcause, exp);
      end
      int_ack = 1'b1; step(); int_ack = 1'b0;
      int_ret = 1'b1; step(); int_ret = 1'b0;
      checks++;
      if (int_fin !== (32'd1 << exp[4:0])) begin
        errors++;
        $display("FAIL fair_fin: fin=%h, want %h", int_fin, 32'd1 << exp[4:0]);
      end
      step();
      checks++;
      if (int_o !== 1'b0 || int_fin !== 32'd0) begin
        errors++;
        $display("FAIL fair_gap: int_o=%b fin=%h, want 0/0", int_o, int_fin);
      end
    end
  endtask

  task automatic test_ignored();
    int cyc;
    do_reset();
    int_ret = 1'b1; step(); int_ret = 1'b0;
    int_ack = 1'b1; step(); int_ack = 1'b0;
    step();
    checks++;
    if (int_o !== 1'b0 || int_fin !== 32'd0) begin
      errors++;
      $display("FAIL ignored_scan: int_o=%b fin=%h, want 0/0", int_o, int_fin);
    end
    int_req = 32'h8; mie = 32'hFFFF_FFFF;
    exp_q.push_back(32'h8000_0003);
    wait_int(40, cyc);
    checks++;
    if (int_o !== 1'b1 || mcause !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL ignored_int: int_o=%b mcause=%h, want 1/80000003", int_o, mcause);
    end
    int_ack = 1'b1; step();
    step(); int_ack = 1'b0; int_req = 32'd0;
    step();
    checks++;
    if (int_o !== 1'b0 || int_fin !== 32'd0 || mcause !== 32'h8000_0003) begin
      errors++;
      $display("FAIL ignored_serve: int_o=%b fin=%h mcause=%h, want 0/0/80000003", int_o, int_fin, mcause);
    end
    int_ret = 1'b1; step(); int_ret = 1'b0;
    checks++;
    if (int_fin !== 32'h8) begin
      errors++;
      $display("FAIL ignored_fin: fin=%h, want 00000008", int_fin);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    int_req = 32'h4; mie = 32'h4;
    wait_int(40, cyc);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    rst = 1'b1; step();
    checks++;
    if ({int_o, int_fin, mcause} !== 65'd0) begin
      errors++;
      $display("FAIL midrst_clear: int_o=%b fin=%h mcause=%h, want 0/0/0", int_o, int_fin, mcause);
    end
    rst = 1'b0; int_req = 32'hFFFF_FFFF; mie = 32'hFFFF_FFFF;
    exp_q.push_back(32'h8000_0000);
    step();
    checks++;
    if (int_o !== 1'b1 || mcause !== exp_q.pop_front() || int_fin !== 32'd0) begin
      errors++;
      $display("FAIL midrst_restart: int_o=%b mcause=%h fin=%h, want 1/80000000/0", int_o, mcause, int_fin);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mask();
    test_fairness();
    test_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
